// File: rtl/polar_pkg.sv
// Shared polar-domain definitions for the NCO and the CORDIC modulator.
// Optional phase modulation (POLAR_NCO_PM_EN) uses wrap_deg from here.
package polar_pkg;

    typedef enum logic [1:0] {StIdle, StWaitAmp, StRun} state_e;

    localparam int DEG180 = 180;
    localparam int DEG360 = 360;

    function automatic int sat_amp(input int a, input int amax);
        if (a > amax) return amax;
        if (a < -amax) return -amax;
        return a;
    endfunction

    // Integer-degree wrap into [-180, 179].
    function automatic int wrap_deg(input int d);
        if (d >= DEG180) return d - DEG360;
        if (d < -DEG180) return d + DEG360;
        return d;
    endfunction

endpackage

// File: rtl/polar_nco_if.sv
// Control, amplitude handshake and polar sample bus of polar_nco.
// pm_in exists only when POLAR_NCO_PM_EN is defined.
interface polar_nco_if #(
    parameter int unsigned W = 8,
    parameter int unsigned F = 8
);
    logic                ce;
    logic                start;
    logic                stop;
    logic signed [W+F:0] freq_in;
    logic                freq_ld;
    logic signed [W:0]   amp_in;
    logic                amp_valid;
    logic                amp_ready;
    logic signed [W:0]   r_out;
    logic signed [W:0]   phi_out;
    logic                valid_out;
    logic                underrun;
    logic                busy;
`ifdef POLAR_NCO_PM_EN
    logic signed [W:0]   pm_in;

    modport master (
        output ce, start, stop, freq_in, freq_ld, amp_in, amp_valid, pm_in,
        input  amp_ready, r_out, phi_out, valid_out, underrun, busy
    );
    modport slave (
        input  ce, start, stop, freq_in, freq_ld, amp_in, amp_valid, pm_in,
        output amp_ready, r_out, phi_out, valid_out, underrun, busy
    );
`else
    modport master (
        output ce, start, stop, freq_in, freq_ld, amp_in, amp_valid,
        input  amp_ready, r_out, phi_out, valid_out, underrun, busy
    );
    modport slave (
        input  ce, start, stop, freq_in, freq_ld, amp_in, amp_valid,
        output amp_ready, r_out, phi_out, valid_out, underrun, busy
    );
`endif
endinterface

// File: rtl/polar_phase_acc.sv
// Fractional-degree phase accumulator wrapping at +/-180 degrees.
// Exposes only the floored integer-degree phase.
module polar_phase_acc
    import polar_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned F = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr_i,
    input  logic                load_i,
    input  logic                step_i,
    input  logic signed [W+F:0] freq_i,
    output logic signed [W:0]   phase_o
);
    localparam int unsigned N = W + F + 2;
    localparam logic signed [N-1:0] Half = N'(DEG180 * (2 ** F));
    localparam logic signed [N-1:0] Full = N'(DEG360 * (2 ** F));

    logic signed [W+F:0] acc_q, acc_d;
    logic signed [N-1:0] base, sum, wrapped;

    always_comb begin
        // load restarts from zero so the first step lands exactly on freq
        base    = load_i ? '0 : {acc_q[W+F], acc_q};
        sum     = base + {freq_i[W+F], freq_i};
        wrapped = sum;
        if (sum >= Half) begin
            wrapped = sum - Full;
        end else if (sum < -Half) begin
            wrapped = sum + Full;
        end
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (load_i || step_i) begin
            acc_d = wrapped[W+F:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    assign phase_o = acc_q[W+F:F];
endmodule

// File: rtl/polar_nco.sv
// Polar sample source feeding the CORDIC AM modulator: wrapped phase plus saturated radius.
// Define POLAR_NCO_PM_EN to add phase modulation via pm_in.
module polar_nco
    import polar_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter int unsigned F    = 8,
    parameter int          AMAX = 156
) (
    input logic        clk,
    input logic        reset,
    polar_nco_if.slave bus_io
);
    state_e              state_q, state_d;
    logic                buf_full_q, buf_full_d;
    logic signed [W:0]   buf_q, buf_d;
    logic signed [W:0]   r_q, r_d;
    logic signed [W:0]   phi_q, phi_d;
    logic                valid_q, valid_d;
    logic                underrun_q, underrun_d;
    logic signed [W+F:0] freq_q, freq_d;
    logic signed [W:0]   phase, phi_next;
    logic                acc_clr, acc_load, acc_step, drain, accept;

    polar_phase_acc #(.W(W), .F(F)) u_acc (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (acc_clr),
        .load_i (acc_load),
        .step_i (acc_step),
        .freq_i (freq_q),
        .phase_o(phase)
    );

`ifdef POLAR_NCO_PM_EN
    assign phi_next = (W+1)'(wrap_deg(int'(phase) + int'(bus_io.pm_in)));
`else
    assign phi_next = phase;
`endif

    // drain needs buf_full_q, accept needs !buf_full_q: never both
    assign accept = bus_io.amp_valid && !buf_full_q;

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        phi_d      = phi_q;
        valid_d    = 1'b0;
        underrun_d = 1'b0;
        acc_clr    = 1'b0;
        acc_load   = 1'b0;
        acc_step   = 1'b0;
        drain      = 1'b0;
        unique case (state_q)
            StIdle: begin
                acc_clr = 1'b1;
                if (bus_io.start && !bus_io.stop) state_d = StWaitAmp;
            end
            StWaitAmp: begin
                if (bus_io.stop) begin
                    state_d = StIdle;
                    acc_clr = 1'b1;
                end else if (bus_io.ce && buf_full_q) begin
                    r_d      = buf_q;
                    phi_d    = '0;
                    valid_d  = 1'b1;
                    acc_load = 1'b1;
                    drain    = 1'b1;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (bus_io.stop) begin
                    state_d = StIdle;
                    acc_clr = 1'b1;
                end else if (bus_io.ce) begin
                    phi_d    = phi_next;
                    acc_step = 1'b1;
                    valid_d  = 1'b1;
                    if (buf_full_q) begin
                        r_d   = buf_q;
                        drain = 1'b1;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        if (drain) begin
            buf_full_d = 1'b0;
        end else if (accept) begin
            buf_d      = (W+1)'(sat_amp(int'(bus_io.amp_in), AMAX));
            buf_full_d = 1'b1;
        end
        freq_d = bus_io.freq_ld ? bus_io.freq_in : freq_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            buf_full_q <= 1'b0;
            buf_q      <= '0;
            r_q        <= '0;
            phi_q      <= '0;
            valid_q    <= 1'b0;
            underrun_q <= 1'b0;
            freq_q     <= '0;
        end else begin
            state_q    <= state_d;
            buf_full_q <= buf_full_d;
            buf_q      <= buf_d;
            r_q        <= r_d;
            phi_q      <= phi_d;
            valid_q    <= valid_d;
            underrun_q <= underrun_d;
            freq_q     <= freq_d;
        end
    end

    assign bus_io.amp_ready = !buf_full_q;
    assign bus_io.r_out     = r_q;
    assign bus_io.phi_out   = phi_q;
    assign bus_io.valid_out = valid_q;
    assign bus_io.underrun  = underrun_q;
    assign bus_io.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_polar_nco.sv
// Directed, table-driven bench for polar_nco: phase wrap, saturation, handshake, control edges.
module tb_polar_nco;
    localparam int W = 8;
    localparam int F = 8;

    typedef struct {
        int freq;
        int amp;
        int exp_r;
        int exp_phi[5];
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    polar_nco_if #(.W(W), .F(F)) bus ();

    polar_nco #(.W(W), .F(F), .AMAX(156)) dut (
        .clk   (clk),
        .reset (reset),
        .bus_io(bus)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic load_freq(input int f);
        bus.freq_in = 17'(f);
        bus.freq_ld = 1'b1;
        step();
        bus.freq_ld = 1'b0;
    endtask

    task automatic push_amp(input int a);
        bus.amp_in    = 9'(a);
        bus.amp_valid = 1'b1;
        step();
        bus.amp_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic ce_cycle();
        bus.ce = 1'b1;
        step();
        bus.ce = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{freq: 23040,  amp: 100,  exp_r: 100,  exp_phi: '{0, 90, -180, -90, 0}};
        vecs[1] = '{freq: 384,    amp: 50,   exp_r: 50,   exp_phi: '{0, 1, 3, 4, 6}};
        vecs[2] = '{freq: 0,      amp: 200,  exp_r: 156,  exp_phi: '{0, 0, 0, 0, 0}};
        vecs[3] = '{freq: 0,      amp: -200, exp_r: -156, exp_phi: '{0, 0, 0, 0, 0}};
        vecs[4] = '{freq: -23040, amp: 10,   exp_r: 10,   exp_phi: '{0, -90, -180, 90, 0}};
        vecs[5] = '{freq: -384,   amp: -7,   exp_r: -7,   exp_phi: '{0, -2, -3, -5, -6}};

        reset         = 1'b1;
        bus.ce        = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.freq_in   = '0;
        bus.freq_ld   = 1'b0;
        bus.amp_in    = '0;
        bus.amp_valid = 1'b0;
`ifdef POLAR_NCO_PM_EN
        bus.pm_in     = '0;
`endif
        step();
        reset = 1'b0;
        step();
        check("rst_r", bus.r_out, 0);
        check("rst_phi", bus.phi_out, 0);
        check("rst_valid", bus.valid_out, 0);
        check("rst_underrun", bus.underrun, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_amp_ready", bus.amp_ready, 1);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            load_freq(vecs[i].freq);
            push_amp(vecs[i].amp);
            pulse_start();
            for (int k = 0; k < 5; k++) begin
                ce_cycle();
                check($sformatf("vec%0d_phi%0d", i, k), bus.phi_out, vecs[i].exp_phi[k]);
                check($sformatf("vec%0d_r%0d", i, k), bus.r_out, vecs[i].exp_r);
                check($sformatf("vec%0d_valid%0d", i, k), bus.valid_out, 1);
                step();
                check($sformatf("vec%0d_gap%0d", i, k), bus.valid_out, 0);
            end
        end

        // Handshake and underrun
        do_reset();
        load_freq(0);
        pulse_start();
        check("hs_busy", bus.busy, 1);
        ce_cycle();
        check("hs_wait_valid", bus.valid_out, 0);
        check("hs_wait_underrun", bus.underrun, 0);
        push_amp(70);
        check("hs_ready_low", bus.amp_ready, 0);
        ce_cycle();
        check("hs_first_valid", bus.valid_out, 1);
        check("hs_first_r", bus.r_out, 70);
        check("hs_ready_back", bus.amp_ready, 1);
        ce_cycle();
        check("hs_underrun", bus.underrun, 1);
        check("hs_under_valid", bus.valid_out, 1);
        check("hs_under_r", bus.r_out, 70);
        step();
        check("hs_underrun_clr", bus.underrun, 0);

        // start and stop together in IDLE
        do_reset();
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("ss_busy", bus.busy, 0);
        step();
        check("ss_busy2", bus.busy, 0);

        // stop coincident with ce keeps the buffered amplitude
        do_reset();
        push_amp(30);
        pulse_start();
        ce_cycle();
        push_amp(40);
        bus.ce   = 1'b1;
        bus.stop = 1'b1;
        step();
        bus.ce   = 1'b0;
        bus.stop = 1'b0;
        check("stop_valid", bus.valid_out, 0);
        check("stop_busy", bus.busy, 0);
        check("stop_buf_kept", bus.amp_ready, 0);
        check("stop_r_hold", bus.r_out, 30);

        // freq_ld with ce: old step applies to that ce
        do_reset();
        load_freq(10 * 256);
        push_amp(5);
        pulse_start();
        ce_cycle();
        check("fl_phi0", bus.phi_out, 0);
        bus.freq_in = 17'(20 * 256);
        bus.freq_ld = 1'b1;
        bus.ce      = 1'b1;
        step();
        bus.ce      = 1'b0;
        bus.freq_ld = 1'b0;
        check("fl_phi1", bus.phi_out, 10);
        ce_cycle();
        check("fl_phi2", bus.phi_out, 20);
        ce_cycle();
        check("fl_phi3", bus.phi_out, 40);

        // asynchronous reset mid-RUN
        do_reset();
        load_freq(45 * 256);
        push_amp(80);
        pulse_start();
        ce_cycle();
        ce_cycle();
        check("ar_pre_r", bus.r_out, 80);
        check("ar_pre_phi", bus.phi_out, 45);
        #3;
        reset = 1'b1;
        #1;
        check("ar_r", bus.r_out, 0);
        check("ar_phi", bus.phi_out, 0);
        check("ar_busy", bus.busy, 0);
        check("ar_valid", bus.valid_out, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        check("ar_ready", bus.amp_ready, 1);
        check("ar_idle", bus.busy, 0);
        ce_cycle();
        check("ar_idle_valid", bus.valid_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
